regfile_wb_port: RTL and testbench

Writeback port controller that owns the register file's single write port (`rd_wren`/`rd_addr`/`rd_data`). It merges single-cycle ALU results with multi-cycle LSU results into one registered write stream. LSU results go through a small in-order queue. The block also exports a per-register pending-write bitmap so decode can stall on RAW hazards until the data has landed in the register file.

---
 rtl/regfile_wb_port.sv | 113 +++++++++++
 tb/tb_regfile_wb_port.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_port.sv
// Single write-port owner for the register file: merges ALU results with queued LSU
// results, with a starvation guard for the queue and a pending-write bitmap for decode.
module regfile_wb_port #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        alu_valid_i,
   input  logic [4:0]  alu_rd_i,
   input  logic [31:0] alu_data_i,
   output logic        alu_stall_o,
   input  logic        lsu_valid_i,
   output logic        lsu_ready_o,
   input  logic [4:0]  lsu_rd_i,
   input  logic [31:0] lsu_data_i,
   output logic        rd_wren_o,
   output logic [4:0]  rd_addr_o,
   output logic [31:0] rd_data_o,
   output logic [31:0] busy_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [WW-1:0] STARVE_LIM = WW'(STARVE_MAX);

   logic [4:0]    r_q_rd   [DEPTH];
   logic [31:0]   r_q_data [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [WW-1:0] r_wait_cnt;
   logic          r_wren;
   logic [4:0]    r_addr;
   logic [31:0]   r_data;

   logic          w_empty;
   logic          w_full;
   logic          w_stall;
   logic          w_alu_act;
   logic          w_pop;
   logic          w_push;
   logic [31:0]   w_busy;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == FULL_CNT);
   assign w_stall   = !w_empty && (r_wait_cnt >= STARVE_LIM);
   assign w_alu_act = alu_valid_i && (alu_rd_i != 5'd0) && !w_stall;
   assign w_pop     = !w_empty && !w_alu_act;
   // x0 loads are handshaken but never occupy a queue slot
   assign w_push    = lsu_valid_i && lsu_ready_o && (lsu_rd_i != 5'd0);

   assign lsu_ready_o = !w_full && !rst_i;
   assign alu_stall_o = w_stall;
   assign rd_wren_o   = r_wren;
   assign rd_addr_o   = r_addr;
   assign rd_data_o   = r_data;
   assign busy_o      = w_busy;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_q_rd[r_wptr]   <= lsu_rd_i;
         r_q_data[r_wptr] <= lsu_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_wait_cnt <= '0;
         r_wren     <= 1'b0;
         r_addr     <= 5'd0;
         r_data     <= 32'd0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);

         if (w_empty || w_pop) r_wait_cnt <= '0;
         else                  r_wait_cnt <= r_wait_cnt + 1'b1;

         if (w_alu_act) begin
            r_wren <= 1'b1;
            r_addr <= alu_rd_i;
            r_data <= alu_data_i;
         end else if (w_pop) begin
            r_wren <= 1'b1;
            r_addr <= r_q_rd[r_rptr];
            r_data <= r_q_data[r_rptr];
         end else begin
            r_wren <= 1'b0;
         end
      end
   end

   // an entry is live when its distance from the read pointer is below the occupancy
   always_comb begin
      logic [PW-1:0] v_off;
      w_busy = 32'd0;
      v_off  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         v_off = PW'(i) - r_rptr;
         if ({1'b0, v_off} < r_count) w_busy[r_q_rd[i]] = 1'b1;
      end
      if (r_wren) w_busy[r_addr] = 1'b1;
      w_busy[0] = 1'b0;
   end

endmodule

// File: tb/tb_regfile_wb_port.sv
// Directed bench for regfile_wb_port: reset, ALU and LSU latency, x0 filtering,
// fill-to-full with starvation pulses, simultaneous pop, and mid-operation reset.
module tb_regfile_wb_port;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        alu_valid_i;
   logic [4:0]  alu_rd_i;
   logic [31:0] alu_data_i;
   logic        alu_stall_o;
   logic        lsu_valid_i;
   logic        lsu_ready_o;
   logic [4:0]  lsu_rd_i;
   logic [31:0] lsu_data_i;
   logic        rd_wren_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] rd_data_o;
   logic [31:0] busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_wb_port #(.DEPTH(4), .STARVE_MAX(3)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .alu_valid_i (alu_valid_i),
      .alu_rd_i    (alu_rd_i),
      .alu_data_i  (alu_data_i),
      .alu_stall_o (alu_stall_o),
      .lsu_valid_i (lsu_valid_i),
      .lsu_ready_o (lsu_ready_o),
      .lsu_rd_i    (lsu_rd_i),
      .lsu_data_i  (lsu_data_i),
      .rd_wren_o   (rd_wren_o),
      .rd_addr_o   (rd_addr_o),
      .rd_data_o   (rd_data_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid_i = 1'b0; alu_rd_i = 5'd0; alu_data_i = 32'd0;
      lsu_valid_i = 1'b0; lsu_rd_i = 5'd0; lsu_data_i = 32'd0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle_inputs();
      tick(); tick();
      #2;
      n_checks++;
      if (lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b exp 0", lsu_ready_o); end
      tick();
      rst_i = 1'b0;
      #2;
      n_checks++;
      if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_high: got %b exp 1", lsu_ready_o); end
      n_checks++;
      if (alu_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", alu_stall_o); end
      n_checks++;
      if (busy_o !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h exp 0", busy_o); end
      n_checks++;
      if ({rd_wren_o, rd_addr_o, rd_data_o} !== 38'd0) begin
         n_fail++; $display("FAIL reset_outputs: got wren=%b addr=%0d data=%h exp all 0", rd_wren_o, rd_addr_o, rd_data_o);
      end
   endtask

   task automatic test_alu_single();
      alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'h1234_5678;
      tick();
      idle_inputs();
      #2;
      n_checks++;
      if ({rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd5, 32'h1234_5678}) begin
         n_fail++; $display("FAIL alu_write: got wren=%b addr=%0d data=%h exp 1/5/12345678", rd_wren_o, rd_addr_o, rd_data_o);
      end
      n_checks++;
      if (busy_o !== 32'h0000_0020) begin n_fail++; $display("FAIL alu_busy: got %h exp 00000020", busy_o); end
      tick();
      #2;
      n_checks++;
      if (rd_wren_o !== 1'b0) begin n_fail++; $display("FAIL alu_write_once: got %b exp 0", rd_wren_o); end
      n_checks++;
      if (busy_o !== 32'd0) begin n_fail++; $display("FAIL alu_busy_clear: got %h exp 0", busy_o); end
   endtask

   task automatic test_back_to_back();
      alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h0000_0033;
      tick();
      alu_rd_i = 5'd4; alu_data_i = 32'h0000_0044;
      #2;
      n_checks++;
      if ({rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd3, 32'h33}) begin
         n_fail++; $display("FAIL b2b_first: got wren=%b addr=%0d data=%h exp 1/3/33", rd_wren_o, rd_addr_o, rd_data_o);
      end
      tick();
      idle_inputs();
      #2;
      n_checks++;
      if ({rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd4, 32'h44}) begin
         n_fail++; $display("FAIL b2b_second: got wren=%b addr=%0d data=%h exp 1/4/44", rd_wren_o, rd_addr_o, rd_data_o);
      end
      tick();
   endtask

   task automatic test_lsu_latency();
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 32'hDEAD_BEEF;
      #2;
      n_checks++;
      if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL lsu_ready: got %b exp 1", lsu_ready_o); end
      tick();
      idle_inputs();
      #2;
      n_checks++;
      if (rd_wren_o !== 1'b0) begin n_fail++; $display("FAIL lsu_no_early_write: got %b exp 0", rd_wren_o); end
      n_checks++;
      if (busy_o !== 32'h0000_0080) begin n_fail++; $display("FAIL lsu_busy_n1: got %h exp 00000080", busy_o); end
      tick();
      #2;
      n_checks++;
      if ({rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin
         n_fail++; $display("FAIL lsu_write: got wren=%b addr=%0d data=%h exp 1/7/deadbeef", rd_wren_o, rd_addr_o, rd_data_o);
      end
      n_checks++;
      if (busy_o !== 32'h0000_0080) begin n_fail++; $display("FAIL lsu_busy_n2: got %h exp 00000080", busy_o); end
      tick();
      #2;
      n_checks++;
      if ({rd_wren_o, busy_o} !== 33'd0) begin n_fail++; $display("FAIL lsu_done: got wren=%b busy=%h exp 0/0", rd_wren_o, busy_o); end
   endtask

   task automatic test_lsu_x0();
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd0; lsu_data_i = 32'hCAFE_0000;
      tick();
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         #2;
         n_checks++;
         if ({rd_wren_o, busy_o} !== 33'd0) begin
            n_fail++; $display("FAIL x0_filter[%0d]: got wren=%b busy=%h exp 0/0", k, rd_wren_o, busy_o);
         end
         tick();
      end
   endtask

   task automatic test_fill();
      logic [4:0]  e_rd   [5] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
      logic [31:0] e_data [5] = '{32'hE000_0000, 32'hE111_1111, 32'hE222_2222, 32'hE333_3333, 32'hE444_4444};
      logic        e_rdy  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      int          pushed = 0;
      logic        exp_stall;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      for (int c = 0; c < 23; c++) begin
         alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'hA000_0000 + 32'(c);
         lsu_valid_i = (pushed < 5);
         if (pushed < 5) begin lsu_rd_i = e_rd[pushed]; lsu_data_i = e_data[pushed]; end
         #2;
         exp_stall = (c > 0) && (c <= 20) && (c % 4 == 0);
         n_checks++;
         if (alu_stall_o !== exp_stall) begin n_fail++; $display("FAIL fill_stall[%0d]: got %b exp %b", c, alu_stall_o, exp_stall); end
         if (c <= 5) begin
            n_checks++;
            if (lsu_ready_o !== e_rdy[c]) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b exp %b", c, lsu_ready_o, e_rdy[c]); end
         end
         if (c >= 1) begin
            if ((c - 1) > 0 && (c - 1) % 4 == 0) begin
               exp_addr = e_rd[(c - 1) / 4 - 1]; exp_data = e_data[(c - 1) / 4 - 1];
            end else begin
               exp_addr = 5'd1; exp_data = 32'hA000_0000 + 32'(c - 1);
            end
            n_checks++;
            if ({rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, exp_addr, exp_data}) begin
               n_fail++;
               $display("FAIL fill_write[%0d]: got wren=%b addr=%0d data=%h exp 1/%0d/%h", c, rd_wren_o, rd_addr_o, rd_data_o, exp_addr, exp_data);
            end
         end
         if (lsu_valid_i && lsu_ready_o) pushed++;
         tick();
      end
      idle_inputs();
      n_checks++;
      if (pushed !== 5) begin n_fail++; $display("FAIL fill_push_count: got %0d exp 5", pushed); end
      tick();
      #2;
      n_checks++;
      if ({rd_wren_o, busy_o} !== 33'd0) begin n_fail++; $display("FAIL fill_drained: got wren=%b busy=%h exp 0/0", rd_wren_o, busy_o); end
   endtask

   task automatic test_simultaneous();
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h9999_0009;
      tick();
      idle_inputs();
      alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h0BAD_0BAD;
      #2;
      n_checks++;
      if (alu_stall_o !== 1'b0) begin n_fail++; $display("FAIL simul_stall: got %b exp 0", alu_stall_o); end
      n_checks++;
      if (busy_o !== 32'h0000_0200) begin n_fail++; $display("FAIL simul_busy: got %h exp 00000200", busy_o); end
      tick();
      #2;
      n_checks++;
      if ({rd_wren_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd9, 32'h9999_0009}) begin
         n_fail++; $display("FAIL simul_pop: got wren=%b addr=%0d data=%h exp 1/9/99990009", rd_wren_o, rd_addr_o, rd_data_o);
      end
      tick();
      idle_inputs();
      #2;
      n_checks++;
      if (rd_wren_o !== 1'b0) begin n_fail++; $display("FAIL simul_x0_nowrite: got %b exp 0", rd_wren_o); end
      tick();
   endtask

   task automatic test_mid_reset();
      logic [4:0] p_rd [3] = '{5'd3, 5'd4, 5'd6};
      for (int c = 0; c < 3; c++) begin
         alu_valid_i = 1'b1; alu_rd_i = 5'd2; alu_data_i = 32'h2222_0000 + 32'(c);
         lsu_valid_i = 1'b1; lsu_rd_i = p_rd[c]; lsu_data_i = 32'h5555_0000 + 32'(c);
         tick();
      end
      idle_inputs();
      #2;
      n_checks++;
      if (busy_o !== 32'h0000_005C) begin n_fail++; $display("FAIL midrst_busy_before: got %h exp 0000005c", busy_o); end
      rst_i = 1'b1;
      #1;
      n_checks++;
      if (lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL midrst_ready_low: got %b exp 0", lsu_ready_o); end
      tick();
      rst_i = 1'b0;
      #2;
      n_checks++;
      if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_high: got %b exp 1", lsu_ready_o); end
      n_checks++;
      if (alu_stall_o !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b exp 0", alu_stall_o); end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if ({rd_wren_o, busy_o} !== 33'd0) begin
            n_fail++; $display("FAIL midrst_quiet[%0d]: got wren=%b busy=%h exp 0/0", k, rd_wren_o, busy_o);
         end
         tick();
         #2;
      end
   endtask

   initial begin
      test_reset();
      test_alu_single();
      test_back_to_back();
      test_lsu_latency();
      test_lsu_x0();
      test_fill();
      test_simultaneous();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
